// File: rtl/hs_feed_pkg.sv
// Shared types and constants for the toggle-handshake feeder.
// The xfer_count statistics counter is built only when SYNC_HANDSHAKE_FEEDER_STATS_EN is defined.
package hs_feed_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10
  } hs_feed_state_t;

endpackage

// File: rtl/hs_feed_fifo.sv
// Payload FIFO for the handshake feeder: DATA_WIDTH x DEPTH storage,
// wrapping read/write pointers and an occupancy count.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module hs_feed_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] headData,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic                  doPush;
  logic                  doPop;

  assign full     = (count == FullCount);
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];

  // Storage write; contents are only meaningful between a push and its pop.
  // NOTE: the storage array has no reset -- count/pointers define validity, and an
  // unreset array maps onto plain RAM/flops without a reset fan-out.
  always_ff @(posedge CLK) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy; power-of-two DEPTH lets the pointers wrap on overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_handshake_feeder.sv
// Source-domain feeder for the toggle-handshake pulse synchronizer.
// Buffers producer words, issues one hs_en pulse per word and holds hs_data
// stable until the synchronizer acknowledges by raising hs_rdy again.
// Optional: define SYNC_HANDSHAKE_FEEDER_STATS_EN to build the xfer_count counter.
module sync_handshake_feeder
  import hs_feed_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  enq_ready,
  output logic                  hs_en,
  input  logic                  hs_rdy,
  output logic [DATA_WIDTH-1:0] hs_data,
  output logic                  busy,
  output logic [AW:0]           count,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  hs_feed_state_t        state;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] headData;

  // NOTE: enq_ready looks at RST combinationally so the producer sees no
  // acceptance during the reset cycle, whatever the FIFO state was before it.
  assign enq_ready = !fifoFull && !RST;
  assign push      = enq_valid && enq_ready;
  assign pop       = (state == IDLE) && !fifoEmpty && hs_rdy;
  assign busy      = (state != IDLE);

  hs_feed_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .pushData (enq_data),
    .pop      (pop),
    .headData (headData),
    .count    (count),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Handshake FSM with registered hs_en (high exactly while in SEND) and hs_data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      hs_en   <= 1'b0;
      hs_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hs_data <= headData;
            hs_en   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          hs_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (hs_rdy) state <= IDLE;
        end
        default: begin
          hs_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SYNC_HANDSHAKE_FEEDER_STATS_EN
  logic [XFER_CNT_W-1:0] xferCnt;

  // Wrap-around count of completed transfers (WAIT -> IDLE).
  always_ff @(posedge CLK) begin
    if (RST) begin
      xferCnt <= '0;
    end else if (state == WAIT && hs_rdy) begin
      xferCnt <= xferCnt + 1'b1;
    end
  end

  assign xfer_count = xferCnt;
`else
  assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_sync_handshake_feeder.sv
// Self-checking bench for sync_handshake_feeder: directed scenarios plus random
// traffic, with a loopback synchronizer model driving hs_rdy and a queue-based
// reference model predicting every output each cycle.
module tb_sync_handshake_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          enq_valid = 1'b0;
  logic [DW-1:0] enq_data = '0;
  logic          enq_ready;
  logic          hs_en;
  logic          hs_rdy = 1'b1;
  logic [DW-1:0] hs_data;
  logic          busy;
  logic [2:0]    count;
  logic [15:0]   xfer_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queued words, transfer timeline, last word sent, transfer total.
  logic [DW-1:0] mQueue [$];
  bit            mPulse;     // hs_en expected high this cycle
  bit            mAwaitAck;  // pulse issued, acknowledge not yet seen
  logic [DW-1:0] mHsData;
  int            mXfer;
  bit            lastAccept;

  // Loopback synchronizer model: hs_rdy drops after a pulse for rtCycles cycles.
  int rtCycles = 6;
  int rtTimer  = 0;
  bit holdRdy  = 1'b0;

  always #5 CLK = ~CLK;

  sync_handshake_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enq_valid  (enq_valid),
    .enq_data   (enq_data),
    .enq_ready  (enq_ready),
    .hs_en      (hs_en),
    .hs_rdy     (hs_rdy),
    .hs_data    (hs_data),
    .busy       (busy),
    .count      (count),
    .xfer_count (xfer_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_xfer();
`ifdef SYNC_HANDSHAKE_FEEDER_STATS_EN
    return 16'(mXfer);
`else
    return 16'd0;
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare, then advance the model
  // to what the coming rising edge should produce.
  task automatic cycle(input logic rst, input logic v, input logic [DW-1:0] d);
    bit accept;
    bit popNow;
    @(negedge CLK);
    RST       = rst;
    enq_valid = v;
    enq_data  = d;
    hs_rdy    = !holdRdy && (rtTimer == 0);
    #1;
    check("enq_ready", enq_ready, !rst && (mQueue.size() != DEPTH));
    check("count", count, mQueue.size());
    check("hs_en", hs_en, mPulse);
    check("busy", busy, mPulse || mAwaitAck);
    check("hs_data", hs_data, mHsData);
    check("xfer_count", xfer_count, exp_xfer());
    lastAccept = 1'b0;
    if (rst) begin
      mQueue.delete();
      mPulse = 0; mAwaitAck = 0; mHsData = '0; mXfer = 0;
      rtTimer = 0;
    end else begin
      accept = v && (mQueue.size() != DEPTH);
      popNow = !mPulse && !mAwaitAck && (mQueue.size() != 0) && hs_rdy;
      if (mPulse) rtTimer = rtCycles;
      else if (rtTimer > 0) rtTimer--;
      if (popNow) begin
        mHsData = mQueue.pop_front();
        mPulse  = 1;
      end else if (mPulse) begin
        mPulse    = 0;
        mAwaitAck = 1;
      end else if (mAwaitAck && hs_rdy) begin
        mAwaitAck = 0;
        mXfer++;
      end
      if (accept) mQueue.push_back(d);
      lastAccept = accept;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    int sent;
    int guard;
    mPulse = 0; mAwaitAck = 0; mHsData = '0; mXfer = 0;
    @(posedge CLK);

    // 1: reset, then idle with hs_rdy high.
    cycle(1'b1, 1'b0, '0);
    idle(2);

    // 2: single word through a 6-cycle round trip.
    rtCycles = 6;
    cycle(1'b0, 1'b1, 8'hA5);
    idle(12);

    // 3: synchronizer held off, five words offered, four accepted; then drain in order.
    holdRdy = 1;
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'(i));
    idle(2);
    holdRdy = 0;
    idle(40);

    // 4: full FIFO while a pop happens; offered word refused, next one lands after wrap.
    holdRdy = 1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h10 + 8'(i));
    holdRdy = 0;
    cycle(1'b0, 1'b1, 8'h77);
    cycle(1'b0, 1'b1, 8'h88);
    idle(45);

    // 5: reset while waiting for the acknowledge with two words queued.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h30 + 8'(i));
    idle(2);
    cycle(1'b1, 1'b0, '0);
    idle(15);

    // 6: 300 back-to-back transfers from reset.
    cycle(1'b1, 1'b0, '0);
    rtCycles = 2;
    sent  = 0;
    guard = 0;
    while ((sent < 300 || mQueue.size() != 0 || mPulse || mAwaitAck) && guard < 5000) begin
      cycle(1'b0, sent < 300, 8'($urandom));
      if (lastAccept) sent++;
      guard++;
    end
    check("xfer_done_in_budget", guard < 5000, 1'b1);
    idle(2);
`ifdef SYNC_HANDSHAKE_FEEDER_STATS_EN
    check("xfer_count_300", xfer_count, 16'd300);
`else
    check("xfer_count_zero", xfer_count, 16'd0);
`endif

    // Random traffic: varying round trip, occasional hold-off and reset.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) rtCycles = $urandom_range(1, 8);
      holdRdy = ($urandom_range(0, 9) == 0) ? !holdRdy : holdRdy;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
    end
    holdRdy = 0;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
